// File: rtl/shift_add_mult32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared types and constants for the shift-and-add multiplier
//            and its ripple-carry adder.
// Contents : MULT_W - operand/product width handled by the adder
//            CNT_W  - width of the step counter (counts 0..MULT_W-1)
//            state_e - control FSM encoding
// Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/shift_add_mult32_rca.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult32_rca
// Purpose  : 32-bit ripple-carry adder, carry-in tied to zero and no
//            carry-out; the sum wraps modulo 2^32.
// Ports    : a_i   [MULT_W-1:0] addend A
//            b_i   [MULT_W-1:0] addend B
//            sum_o [MULT_W-1:0] (A + B) mod 2^MULT_W
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult32_rca
    import mult_pkg::*;
(
    input  logic [MULT_W-1:0] a_i,
    input  logic [MULT_W-1:0] b_i,
    output logic [MULT_W-1:0] sum_o
);

    // Only carries into bits 1..MULT_W-1 exist; the carry out of the top bit
    // is intentionally never formed.
    logic [MULT_W-1:0] carry_w;

    assign carry_w[0] = 1'b0;

    for (genvar i = 0; i < MULT_W; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry_w[i];
        if (i < MULT_W - 1) begin : g_carry
            assign carry_w[i+1] = (a_i[i] & b_i[i]) | (carry_w[i] & (a_i[i] ^ b_i[i]));
        end
    end

endmodule : shift_add_mult32_rca
`default_nettype wire

// File: rtl/shift_add_mult32.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult32
// Purpose  : Sequential radix-2 shift-and-add multiplier producing the low
//            WIDTH bits of a*b. One partial-product addition per RUN cycle
//            through the ripple-carry adder.
// Params   : WIDTH      - operand/product width, must equal MULT_W (32)
//            EARLY_EXIT - 1: stop once remaining multiplier bits are zero
//                         0: always run MULT_W steps
// Ports    : clk, rst_n          clock, async active-low reset
//            in_valid/in_ready   operand handshake (ready only in IDLE)
//            a, b                multiplicand, multiplier
//            out_valid/out_ready product handshake (valid only in DONE)
//            product             (a*b) mod 2^WIDTH, driven from the accumulator
//            busy                high in RUN or DONE
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult32
    import mult_pkg::*;
#(
    parameter int WIDTH      = MULT_W,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] addend_w;
    logic [WIDTH-1:0] sum_w;
    logic             accept_w;
    logic             last_step_w;

    // ------------------------------------------------------------------
    // Datapath: the adder sees the accumulator plus the current partial
    // product (multiplicand gated by the multiplier LSB).
    // ------------------------------------------------------------------
    assign addend_w = mplier_q[0] ? mcand_q : '0;

    shift_add_mult32_rca u_rca (
        .a_i   (acc_q),
        .b_i   (addend_w),
        .sum_o (sum_w)
    );

    assign accept_w = (state_q == IDLE) && in_valid;

    // The step being taken is the last one when the counter reaches the top,
    // or (early exit) when no set multiplier bits remain after this shift.
    assign last_step_w = (cnt_q == CNT_W'(MULT_W - 1)) ||
                         (EARLY_EXIT && (mplier_q[WIDTH-1:1] == '0));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic; unused encodings fall back to IDLE
    // ------------------------------------------------------------------
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept_w ? RUN : IDLE;
            RUN:     state_d = last_step_w ? DONE : RUN;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            RUN:  busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: load on accept, step in RUN, hold otherwise
    // (holding in DONE keeps product stable through any stall).
    // ------------------------------------------------------------------
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (accept_w) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
        end else if (state_q == RUN) begin
            acc_d    = sum_w;
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product = acc_q;

endmodule : shift_add_mult32
`default_nettype wire

// File: tb/tb_shift_add_mult32.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mult32
// Purpose  : Self-checking bench for shift_add_mult32. Two instances are
//            built (EARLY_EXIT=1 and EARLY_EXIT=0) behind a select so one
//            set of stimulus tasks drives either. Expected product and RUN
//            cycle count are queued at each accepted operand pair and
//            compared when the selected instance presents its result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult32;

    typedef struct {
        logic [31:0] prod;
        int          runs;
        int          acc_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sel;        // 0: EARLY_EXIT=1 instance, 1: EARLY_EXIT=0 instance
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_ready;

    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] product0, product1;
    logic        busy0, busy1;

    logic        in_ready, out_valid, busy;
    logic [31:0] product;

    exp_t        sb[$];
    int          cyc;
    int          n_checks;
    int          n_fail;
    bit          ov_seen;

    assign in_valid0 = in_valid & ~sel;
    assign in_valid1 = in_valid &  sel;
    assign in_ready  = sel ? in_ready1  : in_ready0;
    assign out_valid = sel ? out_valid1 : out_valid0;
    assign product   = sel ? product1   : product0;
    assign busy      = sel ? busy1      : busy0;

    shift_add_mult32 #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .a         (a),
        .b         (b),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .product   (product0),
        .busy      (busy0)
    );

    shift_add_mult32 #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .product   (product1),
        .busy      (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Number of RUN steps the selected instance should take for multiplier bv.
    function automatic int exp_runs(input logic [31:0] bv, input bit early);
        if (!early) return 32;
        for (int i = 31; i >= 0; i--) begin
            if (bv[i]) return i + 1;
        end
        return 1;
    endfunction

    // Scoreboard push at accept, compare while the result is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                sb.push_back('{prod: a * b, runs: exp_runs(b, !sel), acc_cyc: cyc + 1});
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!ov_seen) begin
                        check("run_cycles", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].runs));
                        ov_seen = 1'b1;
                    end
                    check("product", product, sb[0].prod);
                    check("in_ready_in_done", 32'(in_ready), 32'd0);
                    check("busy_in_done", 32'(busy), 32'd1);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        ov_seen = 1'b0;
                    end
                end
            end
        end
    end

    // Present a/b with in_valid until accepted; keep leaves in_valid high.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input bit keep);
        int n;
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 200) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            in_valid = 1'b0;
            a        = $urandom;
            b        = $urandom;
        end
    endtask

    task automatic wait_drain();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (n == 200) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mul(input logic [31:0] ta, input logic [31:0] tb_v);
        send(ta, tb_v, 1'b0);
        wait_drain();
    endtask

    initial begin
        int n;
        logic [31:0] pa [4];
        logic [31:0] pb [4];

        cyc       = 0;
        n_checks  = 0;
        n_fail    = 0;
        ov_seen   = 1'b0;
        sel       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_product",   product,        32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a RUN: the operation must vanish.
        send(32'd7, 32'd9, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        ov_seen = 1'b0;
        #1;
        check("midrun_rst_in_ready",  32'(in_ready),  32'd1);
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_product",   product,        32'd0);
        check("midrun_rst_busy",      32'(busy),      32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);   // any out_valid here is flagged as spurious
        check("post_rst_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        mul(32'd3, 32'd5);

        // Full-length instance.
        sel = 1'b1;
        mul(32'd3, 32'd5);
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mul(32'h1234, 32'h0);
        sel = 1'b0;

        // Wrap, zero and early-exit boundaries.
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mul(32'h8000_0000, 32'd2);
        mul(32'h1234, 32'h0);
        mul(32'h0001_0000, 32'h0001_0000);
        mul(32'h0, 32'h55);

        // Backpressure: product must hold for 10 stalled cycles.
        out_ready = 1'b0;
        send(32'd1000, 32'd1000, 1'b0);
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("bp_out_valid_seen", 32'(out_valid), 32'd1);
        repeat (10) @(negedge clk);
        check("bp_hold_product", product, 32'h000F_4240);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_scoreboard_empty",  32'(sb.size()), 32'd0);

        // Back-to-back with in_valid held high.
        pa = '{32'd2, 32'd4, 32'd65535, 32'd0};
        pb = '{32'd3, 32'd5, 32'd65537, 32'd9};
        for (int i = 0; i < 4; i++) send(pa[i], pb[i], i < 3);
        wait_drain();
        check("b2b_scoreboard_empty", 32'(sb.size()), 32'd0);

        // Random pairs on both instances, with varied multiplier lengths.
        for (int i = 0; i < 8; i++) begin
            sel = i[0];
            mul($urandom, $urandom >> $urandom_range(0, 31));
        end
        sel = 1'b0;

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_shift_add_mult32
`default_nettype wire
